// File: rtl/ipgu_ram_reader.sv
// IPGU image RAM raster read master with a 2-entry output buffer.
// Define IPGU_RD_SIDEBAND_EN to add out_sof/out_eol pixel markers.
module ipgu_ram_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH_X      = 300,
  parameter int DEPTH_Y      = 300,
  parameter int ADDR_WIDTH_X = $clog2(DEPTH_X),
  parameter int ADDR_WIDTH_Y = $clog2(DEPTH_Y)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [ADDR_WIDTH_X-1:0]            x0,
  input  logic [ADDR_WIDTH_Y-1:0]            y0,
  input  logic [ADDR_WIDTH_X:0]              win_w,
  input  logic [ADDR_WIDTH_Y:0]              win_h,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [ADDR_WIDTH_X+ADDR_WIDTH_Y-1:0] ram_addr,
  output logic                               ram_cs,
  output logic                               ram_we,
  input  logic [DATA_WIDTH-1:0]              ram_rdData,
`ifdef IPGU_RD_SIDEBAND_EN
  output logic                               out_sof,
  output logic                               out_eol,
`endif
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_valid,
  input  logic                               out_ready
);
  localparam int AX = ADDR_WIDTH_X;
  localparam int AY = ADDR_WIDTH_Y;
  localparam logic [AX:0] LIM_X = (AX+1)'(DEPTH_X);
  localparam logic [AY:0] LIM_Y = (AY+1)'(DEPTH_Y);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_n;

  logic [AX-1:0] cx, xs, xe;
  logic [AY-1:0] cy, ye;
  logic [DATA_WIDTH-1:0] mem [2];
  logic rptr, wptr, rdv, rdv_n;
  logic [1:0] occ, occ_n;
  logic pop, wr, issue, last, accept;
  logic zero_win, bad_win, done_n, err_n;
  logic [AX:0] xsum;
  logic [AY:0] ysum;

  assign ram_we    = 1'b0;
  assign xsum      = {1'b0, x0} + win_w;
  assign ysum      = {1'b0, y0} + win_h;
  assign zero_win  = (win_w == '0) || (win_h == '0);
  assign bad_win   = (xsum > LIM_X) || (ysum > LIM_Y);
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rptr];
  assign pop       = out_valid & out_ready;
  assign wr        = rdv & ((occ != 2'd2) | pop);
  assign occ_n     = occ + {1'b0, wr} - {1'b0, pop};
  // ram_rdData holds until the next read, so unabsorbed data may wait there
  assign rdv_n     = ram_cs | (rdv & ~wr);
  assign last      = (cx == xe) && (cy == ye);

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = err;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (zero_win) begin
            done_n = 1'b1;
            err_n  = 1'b0;
          end else if (bad_win) begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end else begin
            accept  = 1'b1;
            err_n   = 1'b0;
            state_n = READ;
          end
        end
      end
      READ: begin
        issue = ({1'b0, occ_n} + {2'b0, rdv_n}) < 3'd3;
        if (issue && last)
          state_n = DRAIN;
      end
      DRAIN: begin
        if ((occ_n == 2'd0) && !rdv_n) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      ram_cs   <= 1'b0;
      ram_addr <= '0;
      cx       <= '0;
      cy       <= '0;
      xs       <= '0;
      xe       <= '0;
      ye       <= '0;
      rdv      <= 1'b0;
      occ      <= 2'd0;
      rptr     <= 1'b0;
      wptr     <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      state  <= state_n;
      done   <= done_n;
      err    <= err_n;
      busy   <= (state_n != IDLE);
      ram_cs <= issue;
      rdv    <= rdv_n;
      occ    <= occ_n;
      if (issue)
        ram_addr <= {cy, cx};
      if (accept) begin
        xs <= x0;
        cx <= x0;
        cy <= y0;
        xe <= x0 + win_w[AX-1:0] - AX'(1);
        ye <= y0 + win_h[AY-1:0] - AY'(1);
      end else if (issue) begin
        if (cx == xe) begin
          cx <= xs;
          cy <= cy + AY'(1);
        end else begin
          cx <= cx + AX'(1);
        end
      end
      if (wr) begin
        mem[wptr] <= ram_rdData;
        wptr      <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
    end
  end

`ifdef IPGU_RD_SIDEBAND_EN
  logic first, cs_sof, cs_eol, rd_sof, rd_eol;
  logic [1:0] sb_sof, sb_eol;

  assign out_sof = sb_sof[rptr];
  assign out_eol = sb_eol[rptr];

  // markers follow the read through the RAM stage and the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      first  <= 1'b0;
      cs_sof <= 1'b0;
      cs_eol <= 1'b0;
      rd_sof <= 1'b0;
      rd_eol <= 1'b0;
      sb_sof <= 2'b00;
      sb_eol <= 2'b00;
    end else begin
      if (accept)
        first <= 1'b1;
      else if (issue)
        first <= 1'b0;
      if (issue) begin
        cs_sof <= first;
        cs_eol <= (cx == xe);
      end
      if (ram_cs) begin
        rd_sof <= cs_sof;
        rd_eol <= cs_eol;
      end
      if (wr) begin
        sb_sof[wptr] <= rd_sof;
        sb_eol[wptr] <= rd_eol;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ipgu_ram_reader.sv
// Self-checking bench for ipgu_ram_reader against a window-scan model.
// Sideband checks compile in when IPGU_RD_SIDEBAND_EN is defined.
module tb_ipgu_ram_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  x0 = '0;
  logic [8:0]  y0 = '0;
  logic [9:0]  win_w = '0;
  logic [9:0]  win_h = '0;
  logic        busy, done, err;
  logic [17:0] ram_addr;
  logic        ram_cs, ram_we;
  logic [7:0]  ram_rdData = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef IPGU_RD_SIDEBAND_EN
  logic        out_sof, out_eol;
`endif

  logic [7:0] ram_mem [300][300];
  int n_chk = 0;
  int n_err = 0;

  ipgu_ram_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .win_w(win_w), .win_h(win_h),
    .busy(busy), .done(done), .err(err),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_rdData(ram_rdData),
`ifdef IPGU_RD_SIDEBAND_EN
    .out_sof(out_sof), .out_eol(out_eol),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_cs && int'(ram_addr[17:9]) < 300 && int'(ram_addr[8:0]) < 300)
      ram_rdData <= ram_mem[ram_addr[17:9]][ram_addr[8:0]];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input bit rnd);
    for (int r = 0; r < 300; r++)
      for (int c = 0; c < 300; c++)
        ram_mem[r][c] = rnd ? 8'($urandom) : 8'(r + c);
  endtask

  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input int mode, input bit poke);
    int qp[$];
    int qa[$];
    int k, issued, xfer, first_v, last_k, budget, n_rd, pd;
    bit zero, bad, pv, pr, r, any_cs, any_v, seen;
    zero = (w == 0) || (h == 0);
    bad  = !zero && ((x + w > 300) || (y + h > 300));
    if (!zero && !bad)
      for (int j = 0; j < h; j++)
        for (int i = 0; i < w; i++) begin
          qp.push_back(int'(ram_mem[y+j][x+i]));
          qa.push_back(((y + j) << 9) | (x + i));
        end
    n_rd = qp.size();
    @(negedge clk);
    start = 1'b1;
    x0 = 9'(x);
    y0 = 9'(y);
    win_w = 10'(w);
    win_h = 10'(h);
    @(negedge clk);
    start = 1'b0;
    chk("we", ram_we, 0);
    if (zero || bad) begin
      chk("done_imm", done, 1);
      chk("err_flag", err, bad);
      chk("busy_imm", busy, 0);
      any_cs = 0;
      any_v = 0;
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        any_cs |= ram_cs;
        any_v |= out_valid;
        seen |= done;
      end
      chk("no_rd", any_cs, 0);
      chk("no_valid", any_v, 0);
      chk("one_done", seen, 0);
      chk("err_sticky", err, bad);
      return;
    end
    chk("busy_go", busy, 1);
    issued = 0; xfer = 0; first_v = -1; last_k = -1;
    pv = 0; pr = 0; pd = 0; seen = 0; k = 0;
    budget = 4 * n_rd + 30;
    while (k < budget && !seen) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0)
                                           : 1'($urandom_range(0, 1));
      out_ready = r;
      if (ram_cs) begin
        chk("rd_room", (issued - xfer) < 3, 1);
        if (qa.size() > 0) chk("rd_addr", ram_addr, qa.pop_front());
        else chk("rd_count", issued + 1, n_rd);
        issued++;
      end
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
      end
      if (out_valid && first_v < 0) first_v = k;
      if (out_valid && r) begin
        if (qp.size() > 0) chk("px", out_data, qp.pop_front());
        else chk("px_count", xfer + 1, n_rd);
`ifdef IPGU_RD_SIDEBAND_EN
        chk("sof", out_sof, xfer == 0);
        chk("eol", out_eol, (xfer % w) == w - 1);
`endif
        xfer++;
        last_k = k;
      end
      if (done) begin
        seen = 1;
        chk("done_cyc", k, last_k + 1);
      end
      pv = out_valid;
      pr = r;
      pd = int'(out_data);
      if (poke && k == 5) begin
        start = 1'b1;
        x0 = '0;
        y0 = '0;
        win_w = 10'd1;
        win_h = 10'd1;
      end else begin
        start = 1'b0;
      end
      if (!seen) begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", seen, 1);
    chk("px_left", qp.size(), 0);
    chk("rd_left", qa.size(), 0);
    chk("busy_end", busy, 0);
    chk("err_end", err, 0);
    if (mode == 0) begin
      chk("first_lat", first_v, 3);
      chk("last_xfer", last_k, n_rd + 2);
    end
  endtask

  initial begin
    bit quiet;
    int x, y, w, h;
    fill(1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;

    run_cmd(2, 3, 4, 2, 0, 0);
    run_cmd(2, 3, 4, 2, 1, 0);
    run_cmd(296, 299, 4, 1, 0, 0);
    run_cmd(297, 299, 4, 1, 0, 0);
    run_cmd(10, 10, 0, 5, 0, 0);
    run_cmd(5, 7, 12, 3, 0, 1);
    run_cmd(4, 4, 3, 2, 2, 0);

    @(negedge clk);
    start = 1'b1;
    x0 = 9'd2;
    y0 = 9'd3;
    win_w = 10'd4;
    win_h = 10'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_cs", ram_cs, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      quiet |= done | ram_cs | out_valid;
    end
    chk("mrst_quiet", quiet, 0);
    run_cmd(2, 3, 4, 2, 0, 0);

    fill(1'b1);
    for (int n = 0; n < 14; n++) begin
      x = $urandom_range(0, 299);
      y = $urandom_range(0, 299);
      w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      h = $urandom_range(1, 4);
      run_cmd(x, y, w, h, $urandom_range(0, 2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
